ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single data-RAM port (30-bit word address, 32-bit data, 4-bit byte enable) between two requesters: instruction fetch (IF, read-only) and the memory stage (LS, loads and stores).
- Sits between the core pipeline and the RAM model.
- Performs per-cycle arbitration: LS has priority, with a starvation guard for IF.
- Returns read data one cycle later, tagged to the requester that owns it.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (registered).
- if_rdata  out  DATA_W  fetch data.
- ls_req  in  1  load/store request; held until granted.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store word address.
- ls_wdata  in  DATA_W  store data, already lane-shifted.
- ls_be  in  DATA_W/8  store byte enables.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  load data valid (registered).
- ls_rdata  out  DATA_W  load data.
- ram_addr  out  ADDR_W  RAM word address (registered).
- ram_w_data  out  DATA_W  RAM write data (registered).
- ram_byte_en  out  DATA_W/8  RAM byte enables (registered).
- ram_w_en  out  1  RAM write strobe (registered).
- ram_r_en  out  1  RAM read strobe (registered).
- ram_r_data  in  DATA_W  RAM read data, valid the cycle after the ram_r_en cycle.
- stat_conflicts  out  16  conflict-cycle count (present only with the macro; see Optional Feature).
- stat_forced  out  16  forced-IF-grant count (present only with the macro).

Behaviour:
- Reset (async, rst=1): all registered outputs 0, starvation counter 0, owner tag IDLE, stats 0. Grants are 0 while rst=1.
- Arbitration, combinational, each cycle:
  - Only one requester → it is granted.
  - Both requesting → LS wins unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Exactly one of if_gnt/ls_gnt is high, or neither.
- Issue stage, on the posedge following a grant:
  - ram_addr takes the granted address.
  - LS store: ram_w_en=1, ram_r_en=0, ram_w_data=ls_wdata, ram_byte_en=ls_be.
  - Any read (IF or LS load): ram_r_en=1, ram_w_en=0, ram_byte_en=4'b0000.
  - No grant: ram_w_en=0, ram_r_en=0; ram_addr, ram_w_data and ram_byte_en hold their values.
- Owner tag FSM, states IDLE, IF_RD, LS_RD:
  - Set at the issue edge: IF_RD for a fetch read, LS_RD for a load, IDLE for a store or no grant.
  - Next cycle the tag steers ram_r_data to if_rdata/if_rvalid or ls_rdata/ls_rvalid.
  - rvalid pulses for exactly one cycle; the rdata registers hold their value otherwise.
- Latency: grant at cycle N → RAM strobe at cycle N+1 → rvalid at cycle N+2. One access per cycle, fully pipelined.
- Starvation counter:
  - Increments when if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 on any if_gnt, or when if_req=0.
  - A forced IF grant denies LS that cycle; LS then keeps its request held.
- Boundary conditions:
  - Same address, store and read back-to-back: the read returns the new data (the RAM is write-before-read on the next cycle; the arbiter adds no forwarding).
  - Request dropped without grant: legal; no side effects.
  - Reset asserted mid-access: the pending rvalid is discarded and the tag goes to IDLE.
  - ls_be == 0 with ls_we=1: issued as a write with all enables 0 (a no-op at the RAM), still granted.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined:
  - stat_conflicts increments on every cycle with if_req && ls_req.
  - stat_forced increments on every starvation-forced IF grant.
  - Both counters saturate at 16'hFFFF and clear on rst.
- When not defined: both stat ports are tied to 0 and no counter logic is built.

Decomposition:
- Shared package/include: owner-tag encodings (OWN_IDLE, OWN_IF, OWN_LS) and the default STARVE_MAX constant, kept alongside exec_insn_types.
- One natural sub-module, ram_arb_starve_ctr: the saturating starvation counter plus its force output. Everything else stays flat.

Test Plan:
- Reset: assert rst mid-cycle with if_req=1 → all outputs 0 asynchronously; after release, a fetch of addr 0x10 is granted and if_rvalid=1 two cycles later with RAM[0x10].
- Solo store then load: ls store addr 0x20, data 0xDEADBEEF, be 4'b1111; next-cycle load of 0x20 → ls_rvalid with 0xDEADBEEF; if_rvalid stays 0.
- Contention, STARVE_MAX=4: if_req and ls_req both held high → LS granted for 4 cycles, IF granted on the 5th, counter cleared, pattern repeats.
- Routing: alternate IF reads of 0x00/0x04 with LS loads of 0x30 → each rvalid lands on the correct requester with the matching data, with no cross-talk.
- Byte store: ls_be=4'b0100, data 0x00AB0000 to 0x40 (previously 0x11223344) → readback 0x11AB3344.
- With RAM_ARB_STATS_EN: 10 contention cycles at STARVE_MAX=4 → stat_conflicts=10, stat_forced=2.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: owner-tag encodings and the
// default starvation threshold.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } own_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; force_o tells the
// arbiter that IF must win the next contended cycle.
module ram_arb_starve_ctr
    import ram_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic if_gnt_i,
    output logic force_o
);

    localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_C) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between instruction fetch and load/store, LS first with
// an IF starvation guard. Optional counters enabled by RAM_ARB_STATS_EN.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_w_data,
    output logic [DATA_W/8-1:0] ram_byte_en,
    output logic                ram_w_en,
    output logic                ram_r_en,
    input  logic [DATA_W-1:0]   ram_r_data,
    output logic [15:0]         stat_conflicts,
    output logic [15:0]         stat_forced
);

    localparam int BE_W = DATA_W / 8;

    logic starve_force;

    ram_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (if_req),
        .if_gnt_i (if_gnt),
        .force_o  (starve_force)
    );

    assign if_gnt = !rst && if_req && (!ls_req || starve_force);
    assign ls_gnt = !rst && ls_req && !(if_req && starve_force);

    own_e              own_q, own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              if_rv_q, ls_rv_q;
    logic [DATA_W-1:0] if_hold_q, ls_hold_q;

    always_comb begin
        own_d   = OWN_IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        if (if_gnt) begin
            addr_d = if_addr;
            be_d   = '0;
            re_d   = 1'b1;
            own_d  = OWN_IF;
        end else if (ls_gnt) begin
            addr_d = ls_addr;
            if (ls_we) begin
                wdata_d = ls_wdata;
                be_d    = ls_be;
                we_d    = 1'b1;
            end else begin
                be_d  = '0;
                re_d  = 1'b1;
                own_d = OWN_LS;
            end
        end
    end

    // The tag rides with the strobe cycle; rvalid follows when RAM data lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q     <= OWN_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            if_rv_q   <= 1'b0;
            ls_rv_q   <= 1'b0;
            if_hold_q <= '0;
            ls_hold_q <= '0;
        end else begin
            own_q     <= own_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            re_q      <= re_d;
            if_rv_q   <= (own_q == OWN_IF);
            ls_rv_q   <= (own_q == OWN_LS);
            if_hold_q <= if_rv_q ? ram_r_data : if_hold_q;
            ls_hold_q <= ls_rv_q ? ram_r_data : ls_hold_q;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_w_data  = wdata_q;
    assign ram_byte_en = be_q;
    assign ram_w_en    = we_q;
    assign ram_r_en    = re_q;
    assign if_rvalid   = if_rv_q;
    assign ls_rvalid   = ls_rv_q;
    // RAM data arrives in the rvalid cycle, so it is passed through then held.
    assign if_rdata    = if_rv_q ? ram_r_data : if_hold_q;
    assign ls_rdata    = ls_rv_q ? ram_r_data : ls_hold_q;

`ifdef RAM_ARB_STATS_EN
    logic [15:0] conf_q, conf_d;
    logic [15:0] forced_q, forced_d;

    always_comb begin
        conf_d   = conf_q;
        forced_d = forced_q;
        if (if_req && ls_req && conf_q != 16'hFFFF) begin
            conf_d = conf_q + 16'd1;
        end
        if (if_gnt && ls_req && forced_q != 16'hFFFF) begin
            forced_d = forced_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_q   <= '0;
            forced_q <= '0;
        end else begin
            conf_q   <= conf_d;
            forced_q <= forced_d;
        end
    end

    assign stat_conflicts = conf_q;
    assign stat_forced    = forced_q;
`else
    assign stat_conflicts = '0;
    assign stat_forced    = '0;
`endif

endmodule
